// File: rtl/chacha_qr_pkg.sv
// Shared types and constants for the ChaCha/Salsa20 quarter-round engine.
// Salsa20 support is built only when CHACHA_QR_SALSA_EN is defined.
package chacha_qr_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 2;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
  } qr_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  typedef enum logic [CNT_W-1:0] {
    AD0 = 2'd0,
    BC0 = 2'd1,
    AD1 = 2'd2,
    BC1 = 2'd3
  } step_idx_t;

  localparam int unsigned ROT_AD0 = 16;
  localparam int unsigned ROT_BC0 = 12;
  localparam int unsigned ROT_AD1 = 8;
  localparam int unsigned ROT_BC1 = 7;

  localparam int unsigned SALSA_ROT0 = 7;
  localparam int unsigned SALSA_ROT1 = 9;
  localparam int unsigned SALSA_ROT2 = 13;
  localparam int unsigned SALSA_ROT3 = 18;

  function automatic logic [WORD_W-1:0] rol32(input logic [WORD_W-1:0] x,
                                              input int unsigned      r);
    return (x << r) | (x >> (WORD_W - r));
  endfunction

endpackage

// File: rtl/chacha_qr_step.sv
// One combinational quarter-round step; the step index picks which word pair updates.
// The Salsa20 path exists only when CHACHA_QR_SALSA_EN is defined.
module chacha_qr_step
  import chacha_qr_pkg::*;
(
  input  qr_state_t st_i,
  input  step_idx_t step_i,
`ifdef CHACHA_QR_SALSA_EN
  input  logic      salsa_i,
`endif
  output qr_state_t st_o
);

  logic [WORD_W-1:0] ad_sum_c;
  logic [WORD_W-1:0] bc_sum_c;

  assign ad_sum_c = st_i.a + st_i.b;
  assign bc_sum_c = st_i.c + st_i.d;

  always_comb begin
    st_o = st_i;
    case (step_i)
      AD0: begin
        st_o.a = ad_sum_c;
        st_o.d = rol32(st_i.d ^ ad_sum_c, ROT_AD0);
      end
      BC0: begin
        st_o.c = bc_sum_c;
        st_o.b = rol32(st_i.b ^ bc_sum_c, ROT_BC0);
      end
      AD1: begin
        st_o.a = ad_sum_c;
        st_o.d = rol32(st_i.d ^ ad_sum_c, ROT_AD1);
      end
      BC1: begin
        st_o.c = bc_sum_c;
        st_o.b = rol32(st_i.b ^ bc_sum_c, ROT_BC1);
      end
      default: st_o = st_i;
    endcase
`ifdef CHACHA_QR_SALSA_EN
    // Salsa20 overrides the ChaCha result: each step xors one word with a rotated sum.
    if (salsa_i) begin
      st_o = st_i;
      case (step_i)
        AD0:     st_o.b = st_i.b ^ rol32(st_i.a + st_i.d, SALSA_ROT0);
        BC0:     st_o.c = st_i.c ^ rol32(st_i.b + st_i.a, SALSA_ROT1);
        AD1:     st_o.d = st_i.d ^ rol32(st_i.c + st_i.b, SALSA_ROT2);
        BC1:     st_o.a = st_i.a ^ rol32(st_i.d + st_i.c, SALSA_ROT3);
        default: st_o = st_i;
      endcase
    end
`endif
  end

endmodule

// File: rtl/chacha_qr_engine.sv
// Multi-cycle ChaCha quarter-round unit with valid/ready on both sides, STEPS steps per cycle.
// Optional Salsa20 mode (in_salsa port) is enabled by defining CHACHA_QR_SALSA_EN.
module chacha_qr_engine
  import chacha_qr_pkg::*;
#(
  parameter int unsigned STEPS = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
`ifdef CHACHA_QR_SALSA_EN
  input  logic        in_salsa,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [31:0] in_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_c,
  output logic [31:0] out_d
);

  localparam int unsigned LAT = 4 / STEPS;
  // Counter value seen on the final BUSY cycle.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((LAT - 1) * STEPS);

  if (!(STEPS == 1 || STEPS == 2 || STEPS == 4)) begin : g_bad_steps
    $error("chacha_qr_engine: STEPS must be 1, 2 or 4");
  end

  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  qr_state_t        st_q, st_d;
  logic             accept_c;
  logic             last_c;
  qr_state_t        chain_c [STEPS+1];

`ifdef CHACHA_QR_SALSA_EN
  logic             salsa_q, salsa_d;
`endif

  // FSM state register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_c) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; in_ready looks through to out_ready so DONE can reissue on the same edge.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign accept_c = in_valid & in_ready;
  assign last_c   = (cnt_q == LAST_CNT);

  // Step chain: instance i applies step (cnt + i) to the output of instance i-1.
  assign chain_c[0] = st_q;
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    chacha_qr_step u_step (
      .st_i    (chain_c[i]),
      .step_i  (step_idx_t'(cnt_q + CNT_W'(i))),
`ifdef CHACHA_QR_SALSA_EN
      .salsa_i (salsa_q),
`endif
      .st_o    (chain_c[i+1])
    );
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
`ifdef CHACHA_QR_SALSA_EN
    salsa_d = salsa_q;
`endif
    if (accept_c) begin
      st_d  = '{a: in_a, b: in_b, c: in_c, d: in_d};
      cnt_d = '0;
`ifdef CHACHA_QR_SALSA_EN
      salsa_d = in_salsa;
`endif
    end else if (state_q == BUSY) begin
      st_d  = chain_c[STEPS];
      cnt_d = cnt_q + CNT_W'(STEPS);
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      st_q  <= '0;
      cnt_q <= '0;
`ifdef CHACHA_QR_SALSA_EN
      salsa_q <= 1'b0;
`endif
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
`ifdef CHACHA_QR_SALSA_EN
      salsa_q <= salsa_d;
`endif
    end
  end

  assign out_a = st_q.a;
  assign out_b = st_q.b;
  assign out_c = st_q.c;
  assign out_d = st_q.d;

endmodule

// File: doc/chacha_qr_engine.md
Name: chacha_qr_engine

Overview:
- Sequential ChaCha quarter-round engine; successor to the single-step combinational ChaCha step instruction.
- Takes a 4-word state (a,b,c,d) over a valid/ready handshake.
- Applies the four quarter-round steps (ad/16, bc/12, ad/8, bc/7), STEPS of them per cycle, then presents the result over a valid/ready handshake.
- Sits beside the ISE datapath as a multi-cycle functional unit for the core's coprocessor interface.

Parameters:
- STEPS, 1, quarter-round steps per cycle; legal values 1, 2, 4; other values rejected by an elaboration-time check.
- LAT, 4/STEPS, derived localparam (not overridable); cycles from accept to out_valid.

Ports:
- g_clk  input  1  clock; all state updates on rising edge.
- g_resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  input word set valid.
- in_ready  output  1  engine can accept.
- in_a, in_b, in_c, in_d  input  32 each  quarter-round input words.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_a, out_b, out_c, out_d  output  32 each  quarter-round result words.
- in_salsa  input  1  only with CHACHA_QR_SALSA_EN; selects Salsa20 quarter-round.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, step counter=0, out_valid=0, in_ready=1.
  - out_a..out_d=0.
- States:
  - IDLE --(in_valid)--> BUSY: load in_a..in_d into registers, counter=0.
  - BUSY: apply STEPS steps per cycle in order ad0, bc0, ad1, bc1; counter += STEPS.
  - BUSY --(counter+STEPS==4)--> DONE.
  - DONE --(out_ready & !in_valid)--> IDLE.
  - DONE --(out_ready & in_valid)--> BUSY: new load; back-to-back issue.
  - DONE & !out_ready: stay in DONE.
- Outputs:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - out_valid = (state==DONE).
  - out_* driven straight from the state registers; stable while out_valid & !out_ready.
- Latency: accept edge k gives out_valid high from edge k+LAT (4, 2 or 1 cycles).
  - Sustained throughput: one result per LAT+1 cycles when out_ready is held high.
- Step arithmetic, all mod 2^32, rol = rotate left:
  - ad0: a+=b; d=rol(d^a,16).
  - bc0: c+=d; b=rol(b^c,12).
  - ad1: a+=b; d=rol(d^a,8).
  - bc1: c+=d; b=rol(b^c,7).
- STEPS>1: the steps within one cycle are chained combinationally; each step sees the previous step's results.
- in_valid while BUSY or stalled in DONE: ignored, not accepted (in_ready=0). The source must hold its data until accepted.
- Reset mid-operation: computation abandoned, no output produced, IDLE on release.
- out_ready high with out_valid low: no effect.

Optional Feature:
- Macro CHACHA_QR_SALSA_EN.
- Defined:
  - in_salsa port exists and is sampled at accept, then held for the operation.
  - When in_salsa=1, the step sequence is Salsa20:
    - b^=rol(a+d,7)
    - c^=rol(b+a,9)
    - d^=rol(c+b,13)
    - a^=rol(d+c,18)
  - Same counter, latency and handshake as ChaCha mode.
- Not defined: port absent; ChaCha only; no Salsa adders or rotators.

Decomposition:
- Package chacha_qr_pkg holds:
  - typedef for a 4x32 quarter-round state;
  - FSM state enum (IDLE, BUSY, DONE);
  - step-index encoding (AD0, BC0, AD1, BC1);
  - rotation constants: 16/12/8/7, plus 7/9/13/18 for Salsa.
- One sub-module, chacha_qr_step: combinational single step (state in, step index, salsa flag, state out).
  - Instantiated STEPS times in a chain; the first instance takes the step index from the counter.

Test Plan:
- RFC 7539 §2.1.1 vector, all STEPS values: a=11111111 b=01020304 c=9b8d6f43 d=01234567 -> out a=ea2a92f4 b=cb1cf8ce c=4581472e d=5881c4bb. out_valid exactly LAT cycles after accept.
- Back-pressure: out_ready held low 10 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid not accepted. Release -> result consumed once, second item accepted that same edge.
- Back-to-back: in_valid and out_ready held high, 8 random vectors -> results match the golden model in order, one result per LAT+1 cycles.
- Reset: assert g_resetn=0 mid-BUSY -> out_valid=0 and in_ready=1 immediately. No spurious output after release. Next vector computes correctly.
- Salsa mode (macro defined): in_salsa=1, (00000001,0,0,0) -> (08008145,00000080,00010200,20500000). Same vector with in_salsa=0 matches the ChaCha model.
- Wrap-around: a=b=c=d=ffffffff -> every add wraps mod 2^32; result matches the golden model for all STEPS values.
